// File: rtl/drum_strike_detector.sv
// drum_strike_detector
// Turns the gyro/Euler stream from the SPI receive stage into one-cycle
// drum-strike events. A swing starts when gyro Y dips below THRESH and ends on
// the first sample at or above REARM_THRESH. The drum ID comes from the yaw
// zone and pitch tier latched at swing entry. The velocity comes from the peak
// angular rate seen during the swing. After each strike a refractory window
// ignores samples.
//
// Optional feature: define STRIKE_TIMEOUT_EN to abandon a swing that lasts
// SWING_MAX_CYCLES clocks without a rearming sample. The block then returns
// to IDLE with no strike and no refractory period.
module drum_strike_detector #(
  parameter logic signed [15:0] THRESH           = -16'sd2000,
  parameter logic signed [15:0] REARM_THRESH     = -16'sd500,
  parameter logic signed [15:0] YAW_L            = -16'sd1500,
  parameter logic signed [15:0] YAW_R            = 16'sd1500,
  parameter logic signed [15:0] PITCH_HI         = 16'sd2000,
  parameter int unsigned        VEL_SHIFT        = 6,
  parameter int unsigned        REFRACT_CYCLES   = 1200000,
  parameter int unsigned        SWING_MAX_CYCLES = 4800000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gyro_valid,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] euler_yaw,
  input  logic signed [15:0] euler_pitch,
  output logic               strike_valid,
  output logic [2:0]         strike_drum,
  output logic [6:0]         strike_velocity,
  output logic               armed
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SWING   = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        gyro_valid_d;
  logic        sample_evt;
  logic        below_thresh;
  logic        below_rearm;
  logic [16:0] neg_gy;
  logic [1:0]  zone_sel;
  logic [16:0] peak;
  logic [1:0]  zone;
  logic        tier;
  logic [31:0] refr_cnt;
  logic        vld_p0;
  logic        vld_p1;
  logic [2:0]  drum_p1;
  logic [6:0]  vel_p1;
`ifdef STRIKE_TIMEOUT_EN
  logic [31:0] swing_cnt;
  logic        swing_to;
`endif

  // Velocity: peak scaled down, clipped to 7 bits, never reported as zero.
  function automatic logic [6:0] vel_sat(input logic [16:0] pk);
    logic [16:0] sh;
    sh = pk >> VEL_SHIFT;
    if (sh > 17'd127)
      return 7'd127;
    else if (sh == 17'd0)
      return 7'd1;
    else
      return sh[6:0];
  endfunction

  // Only the rising edge of valid counts, so a held-high flag is one sample.
  assign sample_evt   = gyro_valid & ~gyro_valid_d;
  assign below_thresh = (gyro_y < THRESH);
  assign below_rearm  = (gyro_y < REARM_THRESH);
  // The magnitude is kept in 17 bits so that -32768 becomes +32768.
  assign neg_gy       = 17'd0 - {gyro_y[15], gyro_y};

  // Zone selection from yaw: 0 = left, 1 = center, 2 = right.
  always_comb begin
    zone_sel = 2'd1;
    if (euler_yaw < YAW_L)
      zone_sel = 2'd0;
    else if (euler_yaw > YAW_R)
      zone_sel = 2'd2;
  end

`ifdef STRIKE_TIMEOUT_EN
  assign swing_to = (state == S_SWING) && (swing_cnt == SWING_MAX_CYCLES - 1);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (sample_evt && below_thresh)
          state_nxt = S_SWING;
      end
      S_SWING: begin
        if (sample_evt && !below_rearm)
          state_nxt = S_REFRACT;
`ifdef STRIKE_TIMEOUT_EN
        else if (swing_to)
          state_nxt = S_IDLE;
`endif
      end
      S_REFRACT: begin
        if (refr_cnt == 32'd0)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: the armed flag and the strike request for this cycle.
  always_comb begin
    armed  = (state == S_IDLE);
    vld_p0 = (state == S_SWING) && sample_evt && !below_rearm;
  end

  // Swing tracking, the refractory counter and the registered strike outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gyro_valid_d <= 1'b0;
      peak         <= 17'd0;
      zone         <= 2'd0;
      tier         <= 1'b0;
      refr_cnt     <= 32'd0;
      vld_p1       <= 1'b0;
      drum_p1      <= 3'd0;
      vel_p1       <= 7'd0;
    end else begin
      gyro_valid_d <= gyro_valid;
      // p0 -> p1: strike request becomes the registered strobe
      vld_p1       <= vld_p0;
      case (state)
        S_IDLE: begin
          if (sample_evt && below_thresh) begin
            zone <= zone_sel;
            tier <= (euler_pitch > PITCH_HI);
            peak <= neg_gy;
          end
        end
        S_SWING: begin
          if (vld_p0) begin
            drum_p1  <= {tier, zone};
            vel_p1   <= vel_sat(peak);
            refr_cnt <= REFRACT_CYCLES - 1;
          end
`ifdef STRIKE_TIMEOUT_EN
          else if (swing_to) begin
            peak <= 17'd0;
          end
`endif
          else if (sample_evt && (neg_gy > peak)) begin
            // This branch is reached only on a sample below REARM_THRESH.
            peak <= neg_gy;
          end
        end
        S_REFRACT: begin
          if (refr_cnt != 32'd0)
            refr_cnt <= refr_cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef STRIKE_TIMEOUT_EN
  // Swing age counter: zero while idle, counts every cycle spent in SWING.
  always_ff @(posedge clk) begin
    if (rst)
      swing_cnt <= 32'd0;
    else if (state == S_SWING)
      swing_cnt <= swing_cnt + 32'd1;
    else
      swing_cnt <= 32'd0;
  end
`endif

  assign strike_valid    = vld_p1;
  assign strike_drum     = drum_p1;
  assign strike_velocity = vel_p1;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Scoreboard bench for drum_strike_detector. The driver issues gyro samples
// and feeds them to a sample-level behavioural model that pushes the expected
// strikes into a queue. A separate monitor pops and compares whenever the DUT
// raises strike_valid. It also checks that drum and velocity hold between
// strikes.
module tb_drum_strike_detector;

  localparam int R          = 20;   // refractory cycles (shortened)
  localparam int SM         = 300;  // swing timeout cycles (shortened)
  localparam int T_THRESH   = -30;
  localparam int T_REARM    = -10;
  localparam int T_YAW_L    = -1500;
  localparam int T_YAW_R    = 1500;
  localparam int T_PITCH_HI = 2000;
  localparam int T_SHIFT    = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               gyro_valid = 1'b0;
  logic signed [15:0] gyro_y = '0;
  logic signed [15:0] euler_yaw = '0;
  logic signed [15:0] euler_pitch = '0;
  logic               strike_valid;
  logic [2:0]         strike_drum;
  logic [6:0]         strike_velocity;
  logic               armed;

  drum_strike_detector #(
    .THRESH          (-16'sd30),
    .REARM_THRESH    (-16'sd10),
    .YAW_L           (-16'sd1500),
    .YAW_R           (16'sd1500),
    .PITCH_HI        (16'sd2000),
    .VEL_SHIFT       (T_SHIFT),
    .REFRACT_CYCLES  (R),
    .SWING_MAX_CYCLES(SM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gyro_valid     (gyro_valid),
    .gyro_y         (gyro_y),
    .euler_yaw      (euler_yaw),
    .euler_pitch    (euler_pitch),
    .strike_valid   (strike_valid),
    .strike_drum    (strike_drum),
    .strike_velocity(strike_velocity),
    .armed          (armed)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int e;
    int drum;
    int vel;
  } exp_t;
  exp_t expq[$];

  // Reference model. Modes: 0 idle, 1 swing, 2 refractory.
  int m_mode = 0;
  int m_peak = 0;
  int m_drum = 0;
  int m_entry = 0;
  int m_idle_from = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_peak = 0;
    expq.delete();
  endfunction

  // Time-driven transitions up to edge e (refractory expiry, swing timeout).
  function automatic void model_time(input int e);
    if (m_mode == 2 && e > m_idle_from) m_mode = 0;
`ifdef STRIKE_TIMEOUT_EN
    if (m_mode == 1 && e > m_entry + SM) begin
      m_mode = 0;
      m_peak = 0;
    end
`endif
  endfunction

  function automatic void model_sample(input int e, input int gy, input int yaw, input int pitch);
    int zone, v;
    model_time(e);
    if (m_mode == 0) begin
      if (gy < T_THRESH) begin
        zone    = (yaw < T_YAW_L) ? 0 : (yaw > T_YAW_R) ? 2 : 1;
        m_drum  = ((pitch > T_PITCH_HI) ? 4 : 0) + zone;
        m_peak  = -gy;
        m_mode  = 1;
        m_entry = e;
      end
    end else if (m_mode == 1) begin
      if (gy < T_REARM) begin
        if (-gy > m_peak) m_peak = -gy;
      end else begin
        v = m_peak >> T_SHIFT;
        if (v > 127) v = 127;
        if (v == 0) v = 1;
        expq.push_back('{e, m_drum, v});
        m_mode      = 2;
        m_idle_from = e + R;
      end
    end
  endfunction

  function automatic int model_armed(input int k);
    if (m_mode == 0) return 1;
    if (m_mode == 2) return (k >= m_idle_from) ? 1 : 0;
`ifdef STRIKE_TIMEOUT_EN
    return (k >= m_entry + SM) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Monitor: pop expected strikes and check the outputs hold between strikes.
  initial begin
    int last_drum, last_vel;
    exp_t x;
    last_drum = 0;
    last_vel  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_drum = 0;
        last_vel  = 0;
        chk("reset_no_strike", int'(strike_valid), 0);
      end else if (strike_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_strike", 1, 0);
        end else begin
          x = expq.pop_front();
          chk("strike_edge", edge_n, x.e);
          chk("strike_drum", int'(strike_drum), x.drum);
          chk("strike_velocity", int'(strike_velocity), x.vel);
          last_drum = x.drum;
          last_vel  = x.vel;
        end
      end else begin
        chk("drum_hold", int'(strike_drum), last_drum);
        chk("vel_hold", int'(strike_velocity), last_vel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk("armed", int'(armed), model_armed(edge_n));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input int gy, input int yaw, input int pitch);
    @(negedge clk);
    gyro_valid  = 1'b1;
    gyro_y      = 16'(gy);
    euler_yaw   = 16'(yaw);
    euler_pitch = 16'(pitch);
    model_sample(edge_n + 1, gy, yaw, pitch);
    tick();
    @(negedge clk);
    gyro_valid = 1'b0;
    tick();
  endtask

  // Position so that the next sample lands on edge `target`.
  task automatic wait_until(input int target);
    int guard;
    guard = 0;
    while (edge_n < target - 1 && guard < 100000) begin
      tick();
      guard++;
    end
  endtask

  task automatic wait_rearmed();
    model_time(edge_n + 1);
    if (m_mode == 2) wait_until(m_idle_from + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    gyro_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_armed", int'(armed), 1);
    chk("reset_drum", int'(strike_drum), 0);
    chk("reset_velocity", int'(strike_velocity), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int se, gy, yaw, pitch;
    logic signed [15:0] r16;

    do_reset();

    // Basic swing: center, lower tier, velocity 6400>>6 = 100.
    sample(-3000, 0, 0);
    sample(-6400, 0, 0);
    sample(-5000, 0, 0);
    sample(0, 0, 0);
    se = m_idle_from - R;

    // Swing samples throughout the refractory window are ignored.
    while (edge_n + 1 <= se + R) sample(-3000, 0, 0);
    sample(-3000, 0, 0);
    sample(0, 0, 0);                 // velocity 46

    // Sample on the very first IDLE cycle is accepted; right zone.
    wait_until(m_idle_from + 1);
    sample(-4000, 2000, 0);
    sample(0, 2000, 0);              // drum 010, velocity 62

    // Left zone, cymbal tier, saturated peak.
    wait_rearmed();
    sample(-3000, -2000, 2500);
    sample(-32768, -2000, 2500);
    sample(0, -2000, 2500);          // drum 100, velocity 127

    // Shallow swing: velocity floors at 1.
    wait_rearmed();
    sample(-40, 0, 0);
    sample(0, 0, 0);

    // Held-high valid: only the rising edge is a sample.
    wait_rearmed();
    @(negedge clk);
    gyro_valid  = 1'b1;
    gyro_y      = -16'sd3000;
    euler_yaw   = '0;
    euler_pitch = '0;
    model_sample(edge_n + 1, -3000, 0, 0);
    idle(10);
    gyro_y = -16'sd6400;
    idle(40);
    @(negedge clk);
    gyro_valid = 1'b0;
    tick();
    sample(0, 0, 0);                 // velocity 3000>>6 = 46

    // Reset mid-swing: no strike, armed immediately afterwards.
    wait_rearmed();
    sample(-5000, 0, 0);
    idle(3);
    do_reset();
    sample(0, 0, 0);

    // Reset mid-refractory: next swing accepted at once.
    sample(-5000, 0, 0);
    sample(0, 0, 0);
    idle(2);
    do_reset();
    sample(-3000, 1501, 2001);
    sample(-10, 1501, 2001);         // exactly REARM_THRESH rearms

`ifdef STRIKE_TIMEOUT_EN
    // Timeout: swing abandoned without a strike.
    wait_rearmed();
    sample(-3000, 0, 0);
    idle(SM + 5);
    sample(0, 0, 0);
`endif

    // Randomised swings with boundary-heavy values and random gaps.
    for (int i = 0; i < 250; i++) begin
      idle($urandom_range(0, 6));
      case ($urandom_range(0, 9))
        0: begin r16 = 16'($urandom); gy = int'(r16); end
        1: gy = -32768;
        2: gy = -30;
        3: gy = -31;
        4: gy = -10;
        5: gy = -11;
        6: gy = -int'($urandom_range(0, 9000));
        7: gy = 0;
        8: gy = -int'($urandom_range(32, 200));
        default: gy = -int'($urandom_range(2000, 32767));
      endcase
      case ($urandom_range(0, 4))
        0: yaw = -1500;
        1: yaw = -1501;
        2: yaw = 1500;
        3: yaw = 1501;
        default: yaw = int'($urandom_range(0, 8000)) - 4000;
      endcase
      case ($urandom_range(0, 2))
        0: pitch = 2000;
        1: pitch = 2001;
        default: pitch = int'($urandom_range(0, 8000)) - 4000;
      endcase
      sample(gy, yaw, pitch);
    end

    idle(R + 5);
    chk("pending_strikes", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
